// File: rtl/regfile_param.sv
// regfile_param: parametrised register file for the single-cycle core.
//
// Two combinational read ports (A1/RD1, A2/RD2), one synchronous write port
// (A3/WD3/WE3) and a combinational debug read port (DBG_A/DBG_RD). After
// every reset a scrub sweep writes zero into all DEPTH entries, one per
// clock. BUSY is high for the duration, and all read data is forced to 0
// while BUSY is high.
//
// Parameters:
//   WIDTH  - data width in bits (signed data)
//   DEPTH  - number of entries, power of two, >= 2
//   AW     - address width, derived from DEPTH (do not override)
//   BYPASS - 1: a read port whose address matches A3 returns WD3 while WE3=1
//
// Ports:
//   CLK     in   system clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   A1, A2  in   read addresses
//   A3      in   write address
//   WD3     in   write data
//   WE3     in   write enable (ignored while BUSY)
//   RD1,RD2 out  read data
//   DBG_A   in   debug read address
//   DBG_RD  out  debug read data
//   BUSY    out  scrub in progress
//
// Optional build macro REGFILE_ZERO_REG_EN: entry 0 reads as zero on every
// port and writes to it are dropped. The scrub still sweeps all entries.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCRUB    | zeroing entry scnt each clock; reads gated to 0, writes off
// READY    | normal read/write operation
module regfile_param #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter bit BYPASS = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [AW-1:0]           A1,
  input  logic [AW-1:0]           A2,
  input  logic [AW-1:0]           A3,
  input  logic signed [WIDTH-1:0] WD3,
  input  logic                    WE3,
  output logic signed [WIDTH-1:0] RD1,
  output logic signed [WIDTH-1:0] RD2,
  input  logic [AW-1:0]           DBG_A,
  output logic signed [WIDTH-1:0] DBG_RD,
  output logic                    BUSY
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [AW-1:0]           scnt;
  logic [AW-1:0]           scnt_nxt;
  logic                    user_we;
  logic signed [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_SCRUB;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
    end
  end

  // scnt wraps back to 0 on the final scrub edge, so it is already clean
  // for the next scrub.
  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    BUSY      = 1'b0;
    case (state)
      ST_SCRUB: begin
        BUSY     = 1'b1;
        scnt_nxt = scnt + 1'b1;
        if (scnt == AW'(DEPTH - 1)) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        state_nxt = ST_READY;
      end
      default: begin
        state_nxt = ST_SCRUB;
        scnt_nxt  = '0;
      end
    endcase
  end

  // The edge that leaves SCRUB is still a scrub edge, so a WE3 held high
  // across it is ignored.
  always_comb begin
    user_we = WE3 && (state == ST_READY);
    if (ZERO_REG && (A3 == '0)) begin
      user_we = 1'b0;
    end
  end

  // Storage has no reset; the scrub sweep provides the defined contents.
  always_ff @(posedge CLK) begin
    if (state == ST_SCRUB) begin
      mem[scnt] <= '0;
    end else if (user_we) begin
      mem[A3] <= WD3;
    end
  end

  // Priority, lowest to highest: stored value, bypass, zero register,
  // BUSY gate.
  function automatic logic signed [WIDTH-1:0] read_port(
    input logic [AW-1:0]           addr,
    input logic signed [WIDTH-1:0] stored,
    input logic                    busy,
    input logic                    we,
    input logic [AW-1:0]           waddr,
    input logic signed [WIDTH-1:0] wdata
  );
    logic signed [WIDTH-1:0] val;
    val = stored;
    if (BYPASS && we && (addr == waddr)) begin
      val = wdata;
    end
    if (ZERO_REG && (addr == '0)) begin
      val = '0;
    end
    if (busy) begin
      val = '0;
    end
    return val;
  endfunction

  assign RD1    = read_port(A1,    mem[A1],    BUSY, WE3, A3, WD3);
  assign RD2    = read_port(A2,    mem[A2],    BUSY, WE3, A3, WD3);
  assign DBG_RD = read_port(DBG_A, mem[DBG_A], BUSY, WE3, A3, WD3);

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic                    CLK = 1'b0;
  logic                    RST_N;
  logic [AW-1:0]           A1, A2, A3, DBG_A;
  logic signed [WIDTH-1:0] WD3;
  logic                    WE3;
  logic signed [WIDTH-1:0] rd1_n, rd2_n, dbg_n;
  logic signed [WIDTH-1:0] rd1_b, rd2_b, dbg_b;
  logic                    busy_n, busy_b;

  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1'b0)) dut_nobyp (
    .CLK(CLK), .RST_N(RST_N), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
    .RD1(rd1_n), .RD2(rd2_n), .DBG_A(DBG_A), .DBG_RD(dbg_n), .BUSY(busy_n)
  );

  regfile_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1'b1)) dut_byp (
    .CLK(CLK), .RST_N(RST_N), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
    .RD1(rd1_b), .RD2(rd2_b), .DBG_A(DBG_A), .DBG_RD(dbg_b), .BUSY(busy_b)
  );

  always #5 CLK = ~CLK;

  // Reference model: contents as an array, scrub as "cycles remaining";
  // the whole array becomes zero when the scrub finishes.
  logic [WIDTH-1:0] mem_m [DEPTH];
  int               scrub_left;
  int               checks;
  int               errors;

  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (scrub_left > 0) return '0;
    if (ZERO_EN && a == 0) return '0;
    if (byp && WE3 && a == A3) return WD3;
    return mem_m[a];
  endfunction

  task automatic tick();
    @(posedge CLK);
    if (!RST_N) begin
      scrub_left = DEPTH;
    end else if (scrub_left > 0) begin
      scrub_left--;
      if (scrub_left == 0) begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end
    end else if (WE3 && !(ZERO_EN && A3 == 0)) begin
      mem_m[A3] = WD3;
    end
    @(negedge CLK);
  endtask

  task automatic randomize_inputs(input bit we);
    A3    = AW'($urandom_range(0, DEPTH - 1));
    A1    = ($urandom_range(0, 1) == 1) ? A3 : AW'($urandom_range(0, DEPTH - 1));
    A2    = ($urandom_range(0, 2) == 0) ? A3 : AW'($urandom_range(0, DEPTH - 1));
    DBG_A = ($urandom_range(0, 2) == 0) ? A3 : AW'($urandom_range(0, DEPTH - 1));
    WD3   = $urandom;
    WE3   = we;
  endtask

  task automatic test_reset();
    int busy_cnt;
    logic [6*WIDTH-1:0] outs;
    WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; DBG_A = '0; WD3 = '0;
    RST_N = 1'b0;
    scrub_left = DEPTH;
    repeat (3) tick();
    #1;
    checks++;
    outs = {rd1_n, rd2_n, dbg_n, rd1_b, rd2_b, dbg_b};
    if ({busy_n, busy_b} !== 2'b11 || outs !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b%b outs=%h required busy=11 outs=0", busy_n, busy_b, outs);
    end
    RST_N = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < DEPTH + 8; i++) begin
      A1 = AW'($urandom_range(0, DEPTH - 1));
      DBG_A = AW'(i % DEPTH);
      #1;
      checks++;
      if (busy_n !== (scrub_left > 0) || busy_b !== (scrub_left > 0)) begin
        errors++;
        $display("FAIL reset_busy cycle %0d: busy=%b%b required %b", i, busy_n, busy_b, scrub_left > 0);
      end
      if (busy_n === 1'b1) begin
        busy_cnt++;
        checks++;
        outs = {rd1_n, rd2_n, dbg_n, rd1_b, rd2_b, dbg_b};
        if (outs !== '0) begin
          errors++;
          $display("FAIL reset_gate cycle %0d: outs=%h required 0", i, outs);
        end
      end
      tick();
    end
    checks++;
    if (busy_cnt !== DEPTH) begin
      errors++;
      $display("FAIL reset_busy_len: busy cycles=%0d required %0d", busy_cnt, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      DBG_A = AW'(a);
      #1;
      checks++;
      if (dbg_n !== '0 || dbg_b !== '0) begin
        errors++;
        $display("FAIL reset_zeroed entry %0d: dbg=%h/%h required 0", a, dbg_n, dbg_b);
      end
    end
  endtask

  task automatic test_write_read();
    A1 = 5'd5; A2 = 5'd5; A3 = 5'd5; DBG_A = 5'd1; WD3 = -32'sd7; WE3 = 1'b1;
    #1;
    checks++;
    if (rd1_n !== '0 || rd2_n !== '0) begin
      errors++;
      $display("FAIL wr_same_cycle_old: rd1=%h rd2=%h required 0", rd1_n, rd2_n);
    end
    checks++;
    if (rd1_b !== 32'hFFFFFFF9) begin
      errors++;
      $display("FAIL wr_same_cycle_byp: rd1=%h required fffffff9", rd1_b);
    end
    tick();
    WE3 = 1'b0;
    #1;
    checks++;
    if (rd1_n !== 32'hFFFFFFF9 || rd2_n !== rd1_n || rd1_b !== 32'hFFFFFFF9) begin
      errors++;
      $display("FAIL wr_next_cycle: rd1=%h rd2=%h rd1_byp=%h required fffffff9", rd1_n, rd2_n, rd1_b);
    end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] r;
    r = $urandom;
    A3 = 5'd10; WD3 = r; WE3 = 1'b1;
    tick();
    A3 = 5'd9; WD3 = 32'h12345678; A1 = 5'd9; A2 = 5'd10; DBG_A = 5'd9; WE3 = 1'b1;
    #1;
    checks++;
    if (rd1_b !== 32'h12345678 || dbg_b !== 32'h12345678 || rd2_b !== r) begin
      errors++;
      $display("FAIL bypass_on: rd1=%h dbg=%h rd2=%h required 12345678 12345678 %h", rd1_b, dbg_b, rd2_b, r);
    end
    checks++;
    if (rd1_n !== '0 || dbg_n !== '0 || rd2_n !== r) begin
      errors++;
      $display("FAIL bypass_off: rd1=%h dbg=%h rd2=%h required 0 0 %h", rd1_n, dbg_n, rd2_n, r);
    end
    tick();
    WE3 = 1'b0;
  endtask

  task automatic test_scrub_writes();
    bit done;
    RST_N = 1'b0;
    scrub_left = DEPTH;
    tick();
    RST_N = 1'b1;
    A3 = 5'd3; WD3 = 32'hAAAA5555; WE3 = 1'b1; A1 = 5'd3; A2 = 5'd3; DBG_A = 5'd3;
    done = 1'b0;
    for (int i = 0; i < 3 * DEPTH && !done; i++) begin
      #1;
      if (busy_n !== 1'b1) begin
        done = 1'b1;
      end else begin
        checks++;
        if (dbg_n !== '0 || dbg_b !== '0 || rd1_b !== '0) begin
          errors++;
          $display("FAIL scrubwr_gate: dbg=%h/%h rd1=%h required 0", dbg_n, dbg_b, rd1_b);
        end
        tick();
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL scrubwr_timeout: busy=%b required 0 within %0d cycles", busy_n, 3 * DEPTH);
    end
    checks++;
    if (dbg_n !== '0 || rd1_n !== '0 || dbg_b !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL scrubwr_entry3: dbg=%h rd1=%h dbg_byp=%h required 0 0 aaaa5555", dbg_n, rd1_n, dbg_b);
    end
    tick();
    WE3 = 1'b0;
    #1;
    checks++;
    if (dbg_n !== 32'hAAAA5555 || dbg_b !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL scrubwr_first_write: dbg=%h/%h required aaaa5555", dbg_n, dbg_b);
    end
  endtask

  task automatic test_reset_mid_scrub();
    int busy_cnt;
    bit done;
    RST_N = 1'b0;
    scrub_left = DEPTH;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      randomize_inputs(1'b1);
      #1;
      checks++;
      if (busy_n !== 1'b1 || {rd1_n, rd2_n, dbg_n, rd1_b, rd2_b, dbg_b} !== '0) begin
        errors++;
        $display("FAIL midscrub_pre cycle %0d: busy=%b outs nonzero or busy low", i, busy_n);
      end
      tick();
    end
    RST_N = 1'b0;
    scrub_left = DEPTH;
    repeat (2) tick();
    RST_N = 1'b1;
    busy_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 3 * DEPTH && !done; i++) begin
      randomize_inputs(1'b1);
      #1;
      if (busy_n !== 1'b1) begin
        done = 1'b1;
      end else begin
        busy_cnt++;
        tick();
      end
    end
    checks++;
    if (busy_cnt !== DEPTH) begin
      errors++;
      $display("FAIL midscrub_busy_len: busy cycles=%0d required %0d", busy_cnt, DEPTH);
    end
    WE3 = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      DBG_A = AW'(a);
      A1 = AW'(DEPTH - 1 - a);
      #1;
      checks++;
      if (dbg_n !== '0 || rd1_n !== '0) begin
        errors++;
        $display("FAIL midscrub_no_write entry %0d: dbg=%h rd1=%h required 0", a, dbg_n, rd1_n);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [WIDTH-1:0] want;
    want = ZERO_EN ? 32'h0 : 32'hDEADBEEF;
    A3 = 5'd0; WD3 = 32'hDEADBEEF; WE3 = 1'b1; A1 = 5'd0; A2 = 5'd0; DBG_A = 5'd0;
    #1;
    checks++;
    if (rd1_b !== want || rd1_n !== '0) begin
      errors++;
      $display("FAIL zero_same_cycle: rd1_byp=%h rd1=%h required %h 0", rd1_b, rd1_n, want);
    end
    tick();
    WE3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rd1_n !== want || rd1_b !== want || dbg_n !== want) begin
        errors++;
        $display("FAIL zero_later cycle %0d: rd1=%h rd1_byp=%h dbg=%h required %h", i, rd1_n, rd1_b, dbg_n, want);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [6*WIDTH-1:0] got, want;
    for (int i = 0; i < 400; i++) begin
      randomize_inputs($urandom_range(0, 2) != 0);
      #1;
      got  = {rd1_n, rd2_n, dbg_n, rd1_b, rd2_b, dbg_b};
      want = {exp_rd(A1, 1'b0), exp_rd(A2, 1'b0), exp_rd(DBG_A, 1'b0),
              exp_rd(A1, 1'b1), exp_rd(A2, 1'b1), exp_rd(DBG_A, 1'b1)};
      checks++;
      if (got !== want || busy_n !== 1'b0) begin
        errors++;
        $display("FAIL random cycle %0d: got=%h busy=%b required=%h busy=0", i, got, busy_n, want);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    scrub_left = DEPTH;
    RST_N = 1'b0;
    WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; DBG_A = '0; WD3 = '0;
    @(negedge CLK);
    test_reset();
    test_write_read();
    test_bypass();
    test_scrub_writes();
    test_reset_mid_scrub();
    test_zero_reg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor of the single-cycle datapath register file.
- Generalised width and depth; two asynchronous read ports, one synchronous write port, one debug read port.
- Adds a post-reset scrub state machine that zeroes every entry, a BUSY indication while scrubbing, and optional same-cycle write-to-read bypass.
- Sits between decode (addresses) and ALU/writeback (WD3) in the single-cycle core.

Parameters:
- WIDTH, 32, data width in bits (signed).
- DEPTH, 32, number of entries; power of two, at least 2.
- AW, $clog2(DEPTH), address width; derived, not to be overridden.
- BYPASS, 0, 1 = RD1/RD2/DBG_RD return WD3 when WE3 is high and the port address equals A3.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- A1  in  AW  read port 1 address.
- A2  in  AW  read port 2 address.
- A3  in  AW  write address.
- WD3  in  WIDTH  write data (signed).
- WE3  in  1  write enable.
- RD1  out  WIDTH  read data 1 (signed).
- RD2  out  WIDTH  read data 2 (signed).
- DBG_A  in  AW  debug/display read address.
- DBG_RD  out  WIDTH  debug read data (signed).
- BUSY  out  1  high while scrub is in progress.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- FSM states:
  - SCRUB: entered asynchronously when RST_N=0. Counter SCNT is forced to 0 and BUSY is forced to 1 while RST_N=0.
  - READY: normal operation.
- Memory array: has no reset. Contents are undefined until scrub completes.
- SCRUB operation, once RST_N=1:
  - Each rising edge writes 0 to entry SCNT, then increments SCNT.
  - On the edge that writes entry DEPTH-1, the FSM moves to READY and BUSY goes 0.
  - Scrub therefore takes exactly DEPTH cycles after reset release. BUSY is 1 for those DEPTH cycles.
- During SCRUB:
  - WE3 is ignored; no user write occurs.
  - RD1, RD2 and DBG_RD are forced to 0 (combinationally gated by BUSY).
- READY write: on a rising edge with WE3=1, entry A3 <= WD3. The write is visible on the read ports from the following cycle.
- READY read: RD1 = entry[A1], RD2 = entry[A2], DBG_RD = entry[DBG_A]. Reads are combinational, with zero-cycle latency.
- Bypass:
  - BYPASS=1: a read port returns WD3 when WE3=1 and its address equals A3. This applies in READY only.
  - BYPASS=0: a same-cycle read of A3 returns the old value.
- Simultaneous events:
  - A1, A2 and DBG_A may all be equal to each other and to A3; each port resolves independently.
  - WE3 held high on the cycle the FSM enters READY is ignored on that edge. The first user write lands on the first edge after BUSY is observed low.
- Reset mid-operation:
  - RST_N=0 during SCRUB restarts the scrub from SCNT=0.
  - RST_N=0 during READY discards nothing in the array itself; the array is rewritten by the new scrub.
- Width rules: WD3 is stored unmodified. Outputs are WIDTH-bit signed with no extension or truncation. Addresses are AW bits and cannot be out of range.
- Reset values: BUSY=1; RD1=RD2=DBG_RD=0 (via BUSY gating); FSM=SCRUB; SCNT=0.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired to zero; writes with A3=0 are discarded.
  - Reads of address 0 on any port return 0, including under BYPASS=1 with WE3=1, A3=0.
  - Scrub still sweeps all DEPTH addresses, so latency is unchanged.
- Undefined: entry 0 is an ordinary storage location.

Test Plan:
1. Reset release, DEPTH=32:
   - Hold RST_N=0 for 3 cycles, then release.
   - Required: BUSY=1 for exactly 32 rising edges, then 0.
   - Required: RD1/RD2/DBG_RD=0 throughout.
   - Required: afterwards all 32 entries read 0 on DBG_RD.
2. Write then read, BYPASS=0:
   - Stimulus: WE3=1, A3=5, WD3=-7 (0xFFFFFFF9), A1=5.
   - Required: same cycle RD1 = old value (0); the next cycle RD1=0xFFFFFFF9.
   - Required: RD2 with A2=5 matches RD1.
3. Bypass, BYPASS=1:
   - Stimulus: WE3=1, A3=9, WD3=0x12345678, A1=9, A2=10, DBG_A=9.
   - Required: same cycle RD1=DBG_RD=0x12345678, RD2=entry[10].
4. Writes during scrub:
   - Stimulus: WE3=1, A3=3, WD3=0xAAAA5555 asserted across the whole scrub.
   - Required: after BUSY falls, entry 3 reads 0.
   - Required: a write on the next edge reads 0xAAAA5555 one cycle later.
5. Reset mid-scrub:
   - Stimulus: assert RST_N=0 after 10 scrub cycles, release after 2.
   - Required: BUSY stays 1 for a full 32 further cycles.
   - Required: no user write lands before BUSY falls.
6. With REGFILE_ZERO_REG_EN:
   - Stimulus: write A3=0, WD3=0xDEADBEEF, then read A1=0.
   - Required: RD1=0 both in the same cycle (BYPASS=1) and in later cycles.
   - Without the macro: RD1=0xDEADBEEF next cycle.
